// File: rtl/rom_ctrl_pkg.sv
// Shared ROM-controller definitions: the hash feeder's sparse state
// encoding and a small width helper.
package rom_ctrl_pkg;

    // Every pair of codes below differs in at least 3 bits. A single flipped
    // state bit therefore never lands on another legal state.
    localparam int FeederStateWidth = 6;

    typedef enum logic [FeederStateWidth-1:0] {
        FeederFwd     = 6'b000111,
        FeederTop     = 6'b011001,
        FeederWaitDig = 6'b101010,
        FeederDone    = 6'b110100,
        FeederInvalid = 6'b111111
    } feeder_state_e;

    // Bits needed to index 'value' entries. The result is never below 1.
    function automatic int vbits(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/prim_sparse_fsm_flop.sv
// State register for sparse-encoded FSMs. The encoding is kept as a plain
// vector so that the owner can decode illegal values explicitly.
module prim_sparse_fsm_flop #(
    parameter int               Width      = 6,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] state_i,
    output logic [Width-1:0] state_o
);

    // Plain state flop; reset returns the FSM to its start encoding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_o <= ResetValue;
        end else begin
            state_o <= state_i;
        end
    end

endmodule

// File: rtl/rom_ctrl_hash_feeder.sv
// Feeds the non-top ROM words to KMAC and captures the top words as the
// expected digest. It then compares that digest with the one KMAC returns.
// Any protocol violation parks the FSM in a sticky alert state.
module rom_ctrl_hash_feeder
    import rom_ctrl_pkg::*;
#(
    parameter int  RomDepth    = 16,
    parameter int  RomTopCount = 2,
    parameter int  DataWidth   = 32,
    localparam int AW          = vbits(RomDepth),
    localparam int DigestWidth = RomTopCount * DataWidth
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   rom_vld_i,
    output logic                   rom_rdy_o,
    input  logic [DataWidth-1:0]   rom_data_i,
    input  logic [AW-1:0]          rom_addr_i,
    input  logic                   rom_last_nontop_i,
    output logic                   kmac_valid_o,
    input  logic                   kmac_ready_i,
    output logic [DataWidth-1:0]   kmac_data_o,
    output logic                   kmac_last_o,
    input  logic                   kmac_done_i,
    input  logic [DigestWidth-1:0] kmac_digest_i,
    input  logic                   kmac_err_i,
    output logic [DigestWidth-1:0] exp_digest_o,
    output logic [DigestWidth-1:0] digest_o,
    output logic                   done_o,
    output logic                   match_o,
    output logic                   alert_o
);

    // First address of the digest region at the top of the ROM.
    localparam logic [AW-1:0] TopStartAddr = AW'(RomDepth - RomTopCount);
    localparam logic [AW-1:0] TopLastIdx   = AW'(RomTopCount - 1);

    feeder_state_e              state_d, state_q;
    logic [FeederStateWidth-1:0] state_raw;
    logic [DigestWidth-1:0]     exp_digest_d, exp_digest_q;
    logic [DigestWidth-1:0]     digest_d, digest_q;
    logic                       match_d, match_q;
    logic [AW-1:0]              top_idx;
    logic                       in_top_region;
    logic                       fault;

    assign in_top_region = (rom_addr_i >= TopStartAddr);
    assign top_idx       = rom_addr_i - TopStartAddr;

    prim_sparse_fsm_flop #(
        .Width      (FeederStateWidth),
        .ResetValue (FeederFwd)
    ) u_state_regs (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .state_i (state_d),
        .state_o (state_raw)
    );

    assign state_q = feeder_state_e'(state_raw);

    // Next-state, capture/compare and handshake outputs.
    always_comb begin
        state_d      = state_q;
        exp_digest_d = exp_digest_q;
        digest_d     = digest_q;
        match_d      = match_q;
        rom_rdy_o    = 1'b0;
        kmac_valid_o = 1'b0;
        kmac_data_o  = '0;
        kmac_last_o  = 1'b0;
        done_o       = 1'b0;
        match_o      = 1'b0;
        alert_o      = 1'b0;
        fault        = 1'b0;

        unique case (state_q)
            FeederFwd: begin
                // Zero-latency pass-through of the message words.
                kmac_valid_o = rom_vld_i;
                kmac_data_o  = rom_data_i;
                kmac_last_o  = rom_last_nontop_i;
                rom_rdy_o    = kmac_ready_i;
                if (rom_vld_i && in_top_region) begin
                    fault = 1'b1;
                end else if (rom_vld_i && kmac_ready_i && rom_last_nontop_i) begin
                    state_d = FeederTop;
                end
                if (kmac_done_i || kmac_err_i) begin
                    fault = 1'b1;
                end
            end
            FeederTop: begin
                rom_rdy_o = 1'b1;
                if (rom_vld_i) begin
                    if (!in_top_region || (top_idx > TopLastIdx)) begin
                        fault = 1'b1;
                    end else begin
                        for (int i = 0; i < RomTopCount; i++) begin
                            if (top_idx == AW'(i)) begin
                                exp_digest_d[i*DataWidth +: DataWidth] = rom_data_i;
                            end
                        end
                        if (top_idx == TopLastIdx) begin
                            state_d = FeederWaitDig;
                        end
                    end
                end
                if (kmac_done_i || kmac_err_i) begin
                    fault = 1'b1;
                end
            end
            FeederWaitDig: begin
                if (kmac_err_i) begin
                    fault = 1'b1;
                end else if (kmac_done_i) begin
                    digest_d = kmac_digest_i;
                    match_d  = (kmac_digest_i == exp_digest_q);
                    state_d  = FeederDone;
                end
            end
            FeederDone: begin
                done_o  = 1'b1;
                match_o = match_q;
            end
            FeederInvalid: begin
                alert_o = 1'b1;
            end
            default: begin
                // Illegal encoding: flag it now and park in Invalid.
                alert_o = 1'b1;
                fault   = 1'b1;
            end
        endcase

        // A fault overrides any normal progress made in this cycle.
        if (fault) begin
            state_d      = FeederInvalid;
            exp_digest_d = exp_digest_q;
            digest_d     = digest_q;
            match_d      = match_q;
        end
    end

    // Captured expected digest, latched KMAC digest and compare result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exp_digest_q <= '0;
            digest_q     <= '0;
            match_q      <= 1'b0;
        end else begin
            exp_digest_q <= exp_digest_d;
            digest_q     <= digest_d;
            match_q      <= match_d;
        end
    end

    assign exp_digest_o = exp_digest_q;
    assign digest_o     = digest_q;

    // A completed check and an alert are mutually exclusive.
    a_done_alert_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(done_o && alert_o));

    // Completion is sticky until reset.
    a_done_sticky: assert property (@(posedge clk_i) disable iff (!rst_ni)
        done_o |=> done_o);

    // Upstream must hold a stalled word stable. An alerted feeder no longer
    // cares about upstream, so this check is skipped in Invalid.
    a_rom_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rom_vld_i && !rom_rdy_o && (state_q != FeederInvalid))
        |=> $stable({rom_vld_i, rom_addr_i, rom_data_i, rom_last_nontop_i}));

endmodule
